// File: rtl/ddr_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_cmd_sequencer
//  Description : Upstream command stage for the HDR-DDR engine. Fetches a
//                queue of 32-bit command descriptors from the register file,
//                decodes each one into the engine command fields, launches the
//                engine, waits for done (guarded by a watchdog) and writes one
//                16-bit response word per command back to the register file.
//  Ports       :
//    i_sys_clk / i_sys_rst        clock, synchronous active-high reset
//    i_hc_start, i_cmd_count      queue start pulse and descriptor count
//    o_regf_rd_en, o_regf_addr    descriptor read strobe / shared address
//    i_regf_rd_data               descriptor word, valid one cycle after read
//    o_resp_wr_en, o_resp_data    response write strobe / response word
//    o_engine_en, o_regf_*        engine enable and decoded command fields
//    i_engine_done, i_regf_abort,
//    i_regf_error_type            engine completion status (qualified by done)
//    o_seq_busy/done/err          queue status
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_cmd_sequencer #(
    parameter logic [9:0] CMD_BASE_ADDR  = 10'd0,
    parameter logic [9:0] RESP_BASE_ADDR = 10'd64,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter bit         STOP_ON_ERR    = 1'b1
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_hc_start,
    input  logic [3:0]  i_cmd_count,
    output logic        o_regf_rd_en,
    output logic [9:0]  o_regf_addr,
    input  logic [31:0] i_regf_rd_data,
    output logic        o_resp_wr_en,
    output logic [15:0] o_resp_data,
    output logic        o_engine_en,
    output logic        o_regf_toc,
    output logic [4:0]  o_regf_dev_index,
    output logic        o_regf_short_read,
    output logic        o_regf_wroc,
    output logic        o_regf_wr_rd_bit,
    output logic        o_regf_cmd_attr,
    output logic [2:0]  o_regf_dtt,
    output logic [15:0] o_regf_DATA_LEN,
    input  logic        i_engine_done,
    input  logic        i_regf_abort,
    input  logic [3:0]  i_regf_error_type,
    output logic        o_seq_busy,
    output logic        o_seq_done,
    output logic        o_seq_err
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_FETCH  = 3'd1;
    localparam logic [2:0] c_S_LATCH  = 3'd2;
    localparam logic [2:0] c_S_LAUNCH = 3'd3;
    localparam logic [2:0] c_S_WAIT   = 3'd4;
    localparam logic [2:0] c_S_RESP   = 3'd5;
    localparam logic [2:0] c_S_NEXT   = 3'd6;
    localparam logic [2:0] c_S_DONE   = 3'd7;

    // The watchdog only ever needs to reach TIMEOUT_CYCLES-1.
    localparam int                 c_WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WD_W-1:0]  c_WD_ONE  = c_WD_W'(1);

    logic [2:0]        r_state;
    logic [3:0]        r_index;
    logic [3:0]        r_count;
    logic [c_WD_W-1:0] r_wdog;
    logic              r_fail;      // current command ended in abort or timeout

    logic [3:0] w_next_index;
    logic [9:0] w_next_cmd_addr;
    logic [9:0] w_resp_addr;
    logic       w_unused_rsvd;

    assign w_next_index    = r_index + 4'd1;
    assign w_next_cmd_addr = CMD_BASE_ADDR + {6'b0, w_next_index};
    assign w_resp_addr     = RESP_BASE_ADDR + {6'b0, r_index};
    assign w_unused_rsvd   = ^i_regf_rd_data[15:13];

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state           <= c_S_IDLE;
            r_index           <= 4'd0;
            r_count           <= 4'd0;
            r_wdog            <= '0;
            r_fail            <= 1'b0;
            o_regf_rd_en      <= 1'b0;
            o_regf_addr       <= 10'd0;
            o_resp_wr_en      <= 1'b0;
            o_resp_data       <= 16'd0;
            o_engine_en       <= 1'b0;
            o_regf_toc        <= 1'b0;
            o_regf_dev_index  <= 5'd0;
            o_regf_short_read <= 1'b0;
            o_regf_wroc       <= 1'b0;
            o_regf_wr_rd_bit  <= 1'b0;
            o_regf_cmd_attr   <= 1'b0;
            o_regf_dtt        <= 3'd0;
            o_regf_DATA_LEN   <= 16'd0;
            o_seq_busy        <= 1'b0;
            o_seq_done        <= 1'b0;
            o_seq_err         <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state below re-asserts them.
            o_regf_rd_en <= 1'b0;
            o_resp_wr_en <= 1'b0;
            o_seq_done   <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    if (i_hc_start) begin
                        r_index <= 4'd0;
                        if (i_cmd_count == 4'd0) begin
                            r_state <= c_S_DONE;
                        end else begin
                            r_count      <= i_cmd_count;
                            o_seq_err    <= 1'b0;
                            o_seq_busy   <= 1'b1;
                            // Outputs are registered, so the read is issued
                            // on the transition into FETCH.
                            o_regf_rd_en <= 1'b1;
                            o_regf_addr  <= CMD_BASE_ADDR;
                            r_state      <= c_S_FETCH;
                        end
                    end
                end

                c_S_FETCH: begin
                    r_state <= c_S_LATCH;
                end

                c_S_LATCH: begin
                    o_regf_toc        <= i_regf_rd_data[0];
                    o_regf_dev_index  <= i_regf_rd_data[5:1];
                    o_regf_short_read <= i_regf_rd_data[6];
                    o_regf_wroc       <= i_regf_rd_data[7];
                    o_regf_wr_rd_bit  <= i_regf_rd_data[8];
                    o_regf_cmd_attr   <= i_regf_rd_data[9];
                    o_regf_dtt        <= i_regf_rd_data[12:10];
                    o_regf_DATA_LEN   <= i_regf_rd_data[31:16];
                    o_engine_en       <= 1'b1;
                    r_state           <= c_S_LAUNCH;
                end

                c_S_LAUNCH: begin
                    r_wdog  <= '0;
                    r_state <= c_S_WAIT;
                end

                c_S_WAIT: begin
                    // Done is checked first so it wins over a coincident expiry.
                    if (i_engine_done) begin
                        o_engine_en  <= 1'b0;
                        o_resp_wr_en <= 1'b1;
                        o_regf_addr  <= w_resp_addr;
                        o_resp_data  <= {i_regf_error_type, i_regf_abort, 1'b0, r_index, 6'b0};
                        r_fail       <= i_regf_abort;
                        if (i_regf_abort) begin
                            o_seq_err <= 1'b1;
                        end
                        r_state <= c_S_RESP;
                    end else if (r_wdog == c_WD_LAST) begin
                        o_engine_en  <= 1'b0;
                        o_resp_wr_en <= 1'b1;
                        o_regf_addr  <= w_resp_addr;
                        o_resp_data  <= {4'hF, 1'b1, 1'b1, r_index, 6'b0};
                        r_fail       <= 1'b1;
                        o_seq_err    <= 1'b1;
                        r_state      <= c_S_RESP;
                    end else begin
                        r_wdog <= r_wdog + c_WD_ONE;
                    end
                end

                c_S_RESP: begin
                    r_state <= c_S_NEXT;
                end

                c_S_NEXT: begin
                    r_index <= w_next_index;
                    if (w_next_index == r_count) begin
                        r_state <= c_S_DONE;
                    end else if (STOP_ON_ERR && r_fail) begin
                        r_state <= c_S_DONE;
                    end else begin
                        o_regf_rd_en <= 1'b1;
                        o_regf_addr  <= w_next_cmd_addr;
                        r_state      <= c_S_FETCH;
                    end
                end

                c_S_DONE: begin
                    o_seq_done <= 1'b1;
                    o_seq_busy <= 1'b0;
                    r_state    <= c_S_IDLE;
                end

                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_cmd_sequencer
//  Description : Scoreboard bench for ddr_cmd_sequencer. A transaction-level
//                model turns each queue run (descriptors + engine behaviour)
//                into a list of timed events; a monitor pops and compares
//                them as the DUT produces reads, launches, responses and done.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ddr_cmd_sequencer;

    localparam int         TB_T      = 24;
    localparam logic [9:0] CMD_BASE  = 10'd0;
    localparam logic [9:0] RESP_BASE = 10'd64;
    localparam bit         STOP      = 1'b1;

    localparam int K_READ   = 0;
    localparam int K_LAUNCH = 1;
    localparam int K_RESP   = 2;
    localparam int K_DONE   = 3;

    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cmd_count = 4'd0;
    logic [31:0] rd_data = 32'd0;
    logic        done_in = 1'b0;
    logic        abort_in = 1'b0;
    logic [3:0]  etype_in = 4'd0;

    logic        o_regf_rd_en, o_resp_wr_en, o_engine_en;
    logic [9:0]  o_regf_addr;
    logic [15:0] o_resp_data, o_regf_DATA_LEN;
    logic        o_regf_toc, o_regf_short_read, o_regf_wroc, o_regf_wr_rd_bit, o_regf_cmd_attr;
    logic [4:0]  o_regf_dev_index;
    logic [2:0]  o_regf_dtt;
    logic        o_seq_busy, o_seq_done, o_seq_err;

    exp_t        exp_q[$];
    logic [31:0] desc[16];
    int          dly[16];
    logic        ab[16];
    logic [3:0]  et[16];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          launch_idx = 0;

    ddr_cmd_sequencer #(
        .CMD_BASE_ADDR  (CMD_BASE),
        .RESP_BASE_ADDR (RESP_BASE),
        .TIMEOUT_CYCLES (TB_T),
        .STOP_ON_ERR    (STOP)
    ) dut (
        .i_sys_clk         (clk),
        .i_sys_rst         (rst),
        .i_hc_start        (start),
        .i_cmd_count       (cmd_count),
        .o_regf_rd_en      (o_regf_rd_en),
        .o_regf_addr       (o_regf_addr),
        .i_regf_rd_data    (rd_data),
        .o_resp_wr_en      (o_resp_wr_en),
        .o_resp_data       (o_resp_data),
        .o_engine_en       (o_engine_en),
        .o_regf_toc        (o_regf_toc),
        .o_regf_dev_index  (o_regf_dev_index),
        .o_regf_short_read (o_regf_short_read),
        .o_regf_wroc       (o_regf_wroc),
        .o_regf_wr_rd_bit  (o_regf_wr_rd_bit),
        .o_regf_cmd_attr   (o_regf_cmd_attr),
        .o_regf_dtt        (o_regf_dtt),
        .o_regf_DATA_LEN   (o_regf_DATA_LEN),
        .i_engine_done     (done_in),
        .i_regf_abort      (abort_in),
        .i_regf_error_type (etype_in),
        .o_seq_busy        (o_seq_busy),
        .o_seq_done        (o_seq_done),
        .o_seq_err         (o_seq_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fields();
        return {o_regf_DATA_LEN, 3'b000, o_regf_dtt, o_regf_cmd_attr, o_regf_wr_rd_bit,
                o_regf_wroc, o_regf_short_read, o_regf_dev_index, o_regf_toc};
    endfunction

    function automatic logic [63:0] all_outputs();
        return {o_regf_rd_en, o_regf_addr, o_resp_wr_en, o_resp_data, o_engine_en,
                fields(), o_seq_busy, o_seq_done, o_seq_err};
    endfunction

    // Transaction model: from the run's stimulus, list every externally
    // visible event with the cycle in which it must appear.
    task automatic build_model(input int s, input int count);
        int t, e, r;
        bit to, fa, err;
        logic [3:0] ety, idx4;
        t = s;
        err = 1'b0;
        for (int i = 0; i < count; i++) begin
            idx4 = i[3:0];
            exp_q.push_back('{kind: K_READ, addr: (int'(CMD_BASE) + i) % 1024, data: 32'd1, cyc: t});
            e = t + 2;
            exp_q.push_back('{kind: K_LAUNCH, addr: 0, data: desc[i] & 32'hFFFF_1FFF, cyc: e});
            to  = (dly[i] > TB_T);
            fa  = to ? 1'b1 : ab[i];
            ety = to ? 4'hF : et[i];
            r   = e + (to ? TB_T : dly[i]) + 1;
            exp_q.push_back('{kind: K_RESP, addr: (int'(RESP_BASE) + i) % 1024,
                              data: {16'd0, ety, fa, to, idx4, 6'd0}, cyc: r});
            err = err | fa;
            t = r + 2;
            if (STOP && fa) break;
        end
        exp_q.push_back('{kind: K_DONE, addr: 0, data: {31'd0, err}, cyc: t + 1});
    endtask

    task automatic check_evt(input int kind, input int addr, input logic [31:0] data, input string nm);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event addr=%0d data=%h cyc=%0d, required no event", nm, addr, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr != addr || e.data !== data || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: got kind=%0d addr=%0d data=%h cyc=%0d, required kind=%0d addr=%0d data=%h cyc=%0d",
                         nm, kind, addr, data, cyc, e.kind, e.addr, e.data, e.cyc);
            end
        end
    endtask

    // Monitor: compares every DUT-presented event against the scoreboard.
    initial begin : monitor
        logic        en_q;
        logic [31:0] last_fields;
        en_q = 1'b0;
        last_fields = 32'd0;
        forever begin
            @(negedge clk);
            if (o_regf_rd_en && o_resp_wr_en) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_wr_overlap: rd_en=1 resp_wr_en=1 cyc=%0d, required never both", cyc);
            end
            if (o_regf_rd_en)
                check_evt(K_READ, int'(o_regf_addr), {31'd0, o_seq_busy}, "read");
            if (o_engine_en && !en_q) begin
                last_fields = fields();
                check_evt(K_LAUNCH, 0, last_fields, "launch");
            end
            if (o_resp_wr_en) begin
                check_evt(K_RESP, int'(o_regf_addr), {16'd0, o_resp_data}, "resp");
                n_checks++;
                if (fields() !== last_fields || o_engine_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL resp_ctx: fields=%h engine_en=%b, required fields=%h engine_en=0",
                             fields(), o_engine_en, last_fields);
                end
            end
            if (o_seq_done)
                check_evt(K_DONE, 0, {30'd0, o_seq_busy, o_seq_err}, "done");
            en_q = o_engine_en;
        end
    end

    // Register-file and engine model driving the DUT inputs.
    initial begin : env
        bit         armed, rd_pend;
        int         cnt, k;
        logic [9:0] rd_addr, idx;
        armed = 1'b0; rd_pend = 1'b0; cnt = 0; k = 0; rd_addr = 10'd0;
        forever begin
            @(negedge clk);
            // Read data is valid only in the cycle after the strobe.
            if (rd_pend) begin
                idx = rd_addr - CMD_BASE;
                rd_data = desc[idx[3:0]];
            end else begin
                rd_data = $urandom;
            end
            rd_pend = o_regf_rd_en;
            rd_addr = o_regf_addr;
            if (!o_engine_en) begin
                armed = 1'b0;
                done_in = 1'b0;
                abort_in = 1'($urandom);
                etype_in = 4'($urandom);
            end else begin
                if (!armed) begin
                    armed = 1'b1;
                    cnt = 0;
                    k = launch_idx & 15;
                    launch_idx++;
                end
                if (cnt == dly[k]) begin
                    done_in = 1'b1;
                    abort_in = ab[k];
                    etype_in = et[k];
                end else begin
                    done_in = 1'b0;
                    abort_in = 1'($urandom);
                    etype_in = 4'($urandom);
                end
                cnt++;
            end
        end
    end

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d events outstanding, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_queue(input int count, input bit busy_poke, input string nm);
        @(negedge clk);
        start = 1'b1;
        cmd_count = count[3:0];
        launch_idx = 0;
        build_model(cyc + 1, count);
        @(negedge clk);
        start = 1'b0;
        cmd_count = 4'($urandom);
        if (busy_poke) begin
            repeat (6) @(negedge clk);
            start = 1'b1;
            cmd_count = 4'd1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_drain(nm);
    endtask

    task automatic check_zero(input string nm);
        n_checks++;
        if (all_outputs() !== 64'd0) begin
            n_fail++;
            $display("FAIL %s: outputs=%h, required 0", nm, all_outputs());
        end
    endtask

    initial begin : stimulus
        for (int i = 0; i < 16; i++) begin
            desc[i] = 32'd0; dly[i] = 4; ab[i] = 1'b0; et[i] = 4'd0;
        end
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;

        // Single command with the reference descriptor.
        desc[0] = 32'h0010_0283; dly[0] = 20;
        run_queue(1, 1'b0, "single");

        // Three clean commands.
        for (int i = 0; i < 3; i++) begin
            desc[i] = $urandom; dly[i] = 3 + i; ab[i] = 1'b0; et[i] = 4'd0;
        end
        run_queue(3, 1'b0, "three");

        // Abort on command 1 stops the queue.
        for (int i = 0; i < 3; i++) begin
            desc[i] = $urandom; dly[i] = 5; ab[i] = 1'b0; et[i] = 4'd0;
        end
        ab[1] = 1'b1; et[1] = 4'h2;
        run_queue(3, 1'b0, "abort");

        // Engine never finishes.
        ab[0] = 1'b0; et[0] = 4'd0; dly[0] = 200;
        run_queue(1, 1'b0, "timeout");

        // Done on the last watchdog cycle.
        dly[0] = TB_T; et[0] = 4'h5; ab[0] = 1'b0;
        run_queue(1, 1'b0, "simul");

        run_queue(0, 1'b0, "count0");

        // Start pulse while busy is ignored.
        for (int i = 0; i < 4; i++) begin
            desc[i] = $urandom; dly[i] = 10; ab[i] = 1'b0; et[i] = 4'($urandom);
        end
        run_queue(4, 1'b1, "busy_start");

        // Reset in the middle of WAIT.
        for (int i = 0; i < 3; i++) begin
            dly[i] = 100; ab[i] = 1'b0;
        end
        @(negedge clk);
        start = 1'b1; cmd_count = 4'd3; launch_idx = 0;
        build_model(cyc + 1, 3);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        n_checks++;
        if (o_engine_en !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_engine_en: got %b, required 1", o_engine_en);
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_zero("mid_wait_reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) dly[i] = 2 + i;
        run_queue(3, 1'b0, "after_reset");

        // Randomised queues.
        for (int it = 0; it < 8; it++) begin
            int cnt;
            cnt = (it == 0) ? 15 : $urandom_range(1, 15);
            for (int i = 0; i < 16; i++) begin
                desc[i] = $urandom;
                et[i]   = 4'($urandom);
                ab[i]   = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 7) == 0) dly[i] = TB_T + $urandom_range(1, 5);
                else                           dly[i] = $urandom_range(1, TB_T);
            end
            if (it == 0) begin
                for (int i = 0; i < 16; i++) begin
                    ab[i] = 1'b0;
                    dly[i] = $urandom_range(1, 6);
                end
            end
            run_queue(cnt, 1'b0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
